// File: rtl/petajon_irq_pkg.sv
// Shared types and controller constants for the Petajon irq responder.
// Imported by the responder top and its synchronizer.
package petajon_irq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RDCAUSE,
        ST_OFFER,
        ST_RSTE,
        ST_HOLD
    } state_e;

    localparam logic [7:0] CAUSE_ADR = 8'h00;
    localparam logic [7:0] RSTE_ADR  = 8'h14;
    localparam logic [7:0] NMI_CAUSE = 8'hFE;
    localparam logic [2:0] NMI_LEVEL = 3'd7;

    // Edge-reset write payload: low cause bits name the source.
    function automatic logic [31:0] rste_data(
        input logic [4:0] src
    );
        return {27'b0, src};
    endfunction

endpackage

// File: rtl/petajon_sync2.sv
// Two-flop synchronizer for the controller's asynchronous
// irq level and nmi lines.
module petajon_sync2
    import petajon_irq_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two register stages to settle metastability
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/petajon_irq_responder.sv
// CPU-side responder: reads the cause, offers the interrupt
// to the core, then retires the source via edge reset.
module petajon_irq_responder
    import petajon_irq_pkg::*;
#(
    parameter logic [7:0]  pCauseAdr = CAUSE_ADR,
    parameter logic [7:0]  pRsteAdr  = RSTE_ADR,
    parameter logic [7:0]  pNmiCause = NMI_CAUSE,
    parameter int unsigned pTimeout  = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [2:0]  irq_i,
    input  logic        nmi_i,
    input  logic [2:0]  im_i,
    input  logic        ie_i,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [7:0]  adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    output logic        req_o,
    output logic        req_nmi_o,
    output logic [2:0]  req_level_o,
    output logic [7:0]  req_cause_o,
    input  logic        core_ack_i,
    output logic        spurious_o,
    output logic        timeout_o
);

    localparam logic [7:0] TMO_LAST = 8'(pTimeout);

    logic [2:0] irq_s;
    logic [2:0] irq_q;
    logic       nmi_s;
    logic       nmi_q;
    logic       nmi_pend;
    logic       nmi_rise;
    logic       nmi_take;
    logic       irq_qual;
    logic [7:0] cnt;
    state_e     state;
    logic       unused_dat;

    petajon_sync2 #(.W(3)) u_sync_irq (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d      (irq_i),
        .q      (irq_s)
    );

    petajon_sync2 #(.W(1)) u_sync_nmi (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d      (nmi_i),
        .q      (nmi_s)
    );

    assign nmi_rise = nmi_s & ~nmi_q;
    assign nmi_take = (state == ST_IDLE) & nmi_pend;
    assign irq_qual = ie_i & (irq_s > im_i) & (irq_s == irq_q);
    assign unused_dat = ^dat_i[31:8];

    // Level history for qualification; NMI edges held until taken
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q    <= 3'd0;
            nmi_q    <= 1'b0;
            nmi_pend <= 1'b0;
        end else begin
            irq_q    <= irq_s;
            nmi_q    <= nmi_s;
            nmi_pend <= nmi_rise | (nmi_pend & ~nmi_take);
        end
    end

    // Service sequencer with all outputs registered
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            cnt         <= 8'd0;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            adr_o       <= 8'h00;
            dat_o       <= 32'h0;
            req_o       <= 1'b0;
            req_nmi_o   <= 1'b0;
            req_level_o <= 3'd0;
            req_cause_o <= 8'h00;
            spurious_o  <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            spurious_o <= 1'b0;
            timeout_o  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (nmi_pend) begin
                        req_o       <= 1'b1;
                        req_nmi_o   <= 1'b1;
                        req_level_o <= NMI_LEVEL;
                        req_cause_o <= pNmiCause;
                        state       <= ST_OFFER;
                    end else if (irq_qual) begin
                        req_nmi_o   <= 1'b0;
                        req_level_o <= irq_s;
                        cyc_o       <= 1'b1;
                        stb_o       <= 1'b1;
                        we_o        <= 1'b0;
                        adr_o       <= pCauseAdr;
                        dat_o       <= 32'h0;
                        cnt         <= 8'd1;
                        state       <= ST_RDCAUSE;
                    end
                end
                ST_RDCAUSE: begin
                    if (ack_i) begin
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        cnt   <= 8'd0;
                        if (dat_i[7:0] == 8'h00) begin
                            spurious_o <= 1'b1;
                            state      <= ST_HOLD;
                        end else begin
                            req_cause_o <= dat_i[7:0];
                            req_o       <= 1'b1;
                            state       <= ST_OFFER;
                        end
                    end else if (cnt == TMO_LAST) begin
                        cyc_o     <= 1'b0;
                        stb_o     <= 1'b0;
                        timeout_o <= 1'b1;
                        cnt       <= 8'd0;
                        state     <= ST_HOLD;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_OFFER: begin
                    if (core_ack_i) begin
                        req_o <= 1'b0;
                        cnt   <= 8'd0;
                        if (req_nmi_o) begin
                            state <= ST_HOLD;
                        end else begin
                            cyc_o <= 1'b1;
                            stb_o <= 1'b1;
                            we_o  <= 1'b1;
                            adr_o <= pRsteAdr;
                            dat_o <= rste_data(req_cause_o[4:0]);
                            cnt   <= 8'd1;
                            state <= ST_RSTE;
                        end
                    end
                end
                ST_RSTE: begin
                    if (ack_i || cnt == TMO_LAST) begin
                        cyc_o     <= 1'b0;
                        stb_o     <= 1'b0;
                        we_o      <= 1'b0;
                        dat_o     <= 32'h0;
                        timeout_o <= ~ack_i;
                        cnt       <= 8'd0;
                        state     <= ST_HOLD;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_HOLD: begin
                    // Encoder lags edge reset by two clocks
                    if (cnt == 8'd1) begin
                        cnt   <= 8'd0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_petajon_irq_responder.sv
// Bench for petajon_irq_responder: vector table, random
// episodes against a transaction-level model, corner sequences.
module tb_petajon_irq_responder;

    typedef struct packed {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
    } bus_t;

    typedef struct packed {
        logic       nmi;
        logic [2:0] lvl;
        logic [7:0] cause;
    } off_t;

    typedef struct {
        logic [2:0] irq;
        logic [2:0] im;
        logic       ie;
        logic       nmi;
        logic [7:0] cause;
        int         bdly;
        int         cdly;
    } ep_t;

    typedef struct {
        ep_t ep;
        int  exp_lat;
        int  exp_nbus;
        int  exp_noff;
    } vec_t;

    logic        clk_i;
    logic        rst_ni;
    logic [2:0]  irq_i;
    logic        nmi_i;
    logic [2:0]  im_i;
    logic        ie_i;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [7:0]  adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        req_o;
    logic        req_nmi_o;
    logic [2:0]  req_level_o;
    logic [7:0]  req_cause_o;
    logic        core_ack_i;
    logic        spurious_o;
    logic        timeout_o;

    int n_chk;
    int n_err;

    bit         bus_en;
    int         bus_dly;
    logic [7:0] rd_data;
    bit         core_en;
    int         core_dly;

    bus_t bus_q[$];
    off_t off_q[$];
    int   spur_n;
    int   tmo_n;

    bus_t exp_bus[$];
    off_t exp_off[$];
    int   exp_spur;
    int   exp_tmo;
    int   exp_lat;

    vec_t tbl[8];
    ep_t  e;
    int   lat;
    int   t;
    int   t_fall;
    int   t_nmi;
    logic pc;
    logic mon_pr;
    off_t mon_prv;
    int   bus_w;
    int   core_w;

    petajon_irq_responder dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .irq_i       (irq_i),
        .nmi_i       (nmi_i),
        .im_i        (im_i),
        .ie_i        (ie_i),
        .cyc_o       (cyc_o),
        .stb_o       (stb_o),
        .we_o        (we_o),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .dat_i       (dat_i),
        .ack_i       (ack_i),
        .req_o       (req_o),
        .req_nmi_o   (req_nmi_o),
        .req_level_o (req_level_o),
        .req_cause_o (req_cause_o),
        .core_ack_i  (core_ack_i),
        .spurious_o  (spurious_o),
        .timeout_o   (timeout_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Bus target: ack after bus_dly waited cycles, log the access
    initial begin
        ack_i = 1'b0;
        dat_i = 32'h0;
        bus_w = 0;
        forever begin
            @(posedge clk_i);
            #2;
            if (ack_i) begin
                ack_i = 1'b0;
                bus_w = 0;
            end else if (!cyc_o) begin
                bus_w = 0;
            end else if (stb_o && bus_en) begin
                if (bus_w >= bus_dly) begin
                    ack_i = 1'b1;
                    dat_i = {24'h5A5A5A, rd_data};
                    bus_q.push_back(bus_t'{we_o, adr_o,
                                    we_o ? dat_o : 32'h0});
                end else begin
                    bus_w++;
                end
            end
        end
    end

    // Core: accept an offer after core_dly cycles
    initial begin
        core_ack_i = 1'b0;
        core_w = 0;
        forever begin
            @(posedge clk_i);
            #2;
            if (core_ack_i) begin
                core_ack_i = 1'b0;
                core_w = 0;
            end else if (req_o && core_en) begin
                if (core_w >= core_dly) core_ack_i = 1'b1;
                else core_w++;
            end else begin
                core_w = 0;
            end
        end
    end

    // Monitor: pulses, offers, and offer stability while held
    initial begin
        mon_pr = 1'b0;
        mon_prv = '0;
        forever begin
            @(posedge clk_i);
            #3;
            if (timeout_o) tmo_n++;
            if (spurious_o) spur_n++;
            if (req_o && !mon_pr)
                off_q.push_back(off_t'{req_nmi_o, req_level_o,
                                       req_cause_o});
            else if (req_o && mon_pr)
                chk("offer stable",
                    off_t'{req_nmi_o, req_level_o, req_cause_o},
                    mon_prv);
            mon_pr = req_o;
            mon_prv = off_t'{req_nmi_o, req_level_o, req_cause_o};
        end
    end

    task automatic clr_logs();
        bus_q.delete();
        off_q.delete();
        spur_n = 0;
        tmo_n = 0;
        exp_bus.delete();
        exp_off.delete();
        exp_spur = 0;
        exp_tmo = 0;
    endtask

    // Transaction-level expectation for one episode
    task automatic model(input ep_t m);
        exp_bus.delete();
        exp_off.delete();
        exp_spur = 0;
        exp_tmo = 0;
        exp_lat = -1;
        if (m.nmi) begin
            exp_lat = 4;
            exp_off.push_back(off_t'{1'b1, 3'd7, 8'hFE});
        end else if (m.ie && m.irq > m.im) begin
            exp_lat = 4;
            exp_bus.push_back(bus_t'{1'b0, 8'h00, 32'h0});
            if (m.cause == 8'h00) begin
                exp_spur = 1;
            end else begin
                exp_off.push_back(off_t'{1'b0, m.irq, m.cause});
                exp_bus.push_back(bus_t'{1'b1, 8'h14,
                                  32'(m.cause % 32)});
            end
        end
    endtask

    task automatic cmp_logs(input string tag);
        chk({tag, " bus count"}, bus_q.size(), exp_bus.size());
        for (int i = 0; i < bus_q.size() && i < exp_bus.size(); i++)
            chk($sformatf("%s bus%0d", tag, i), bus_q[i], exp_bus[i]);
        chk({tag, " offer count"}, off_q.size(), exp_off.size());
        for (int i = 0; i < off_q.size() && i < exp_off.size(); i++)
            chk($sformatf("%s offer%0d", tag, i), off_q[i], exp_off[i]);
        chk({tag, " spurious"}, spur_n, exp_spur);
        chk({tag, " timeout"}, tmo_n, exp_tmo);
    endtask

    task automatic settle(input string tag);
        int idle = 0;
        int n = 0;
        while (idle < 6 && n < 600) begin
            step();
            n++;
            if (cyc_o || req_o) idle = 0;
            else idle++;
        end
        chk({tag, " settle"}, idle, 6);
    endtask

    task automatic wait_act(output int l);
        l = -1;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (cyc_o || req_o) begin
                l = n;
                break;
            end
        end
    endtask

    task automatic run_ep(input ep_t m, input string tag,
                          output int l);
        clr_logs();
        bus_en = 1'b1;
        core_en = 1'b1;
        rd_data = m.cause;
        bus_dly = m.bdly;
        core_dly = m.cdly;
        irq_i = m.irq;
        im_i = m.im;
        ie_i = m.ie;
        nmi_i = m.nmi;
        l = -1;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (n == 2) nmi_i = 1'b0;
            if (cyc_o || req_o) begin
                l = n;
                break;
            end
        end
        nmi_i = 1'b0;
        irq_i = 3'd0;
        settle(tag);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_ni = 1'b0;
        irq_i = 3'd0;
        nmi_i = 1'b0;
        im_i = 3'd0;
        ie_i = 1'b0;
        bus_en = 1'b1;
        bus_dly = 0;
        rd_data = 8'h00;
        core_en = 1'b1;
        core_dly = 0;
        clr_logs();
        repeat (3) step();
        chk("reset outputs",
            {cyc_o, stb_o, we_o, adr_o, dat_o, req_o, req_nmi_o,
             req_level_o, req_cause_o, spurious_o, timeout_o}, 64'h0);
        rst_ni = 1'b1;
        repeat (2) step();

        tbl[0] = '{ep: '{3'd3, 3'd1, 1'b1, 1'b0, 8'h25, 1, 0},
                   exp_lat: 4, exp_nbus: 2, exp_noff: 1};
        tbl[1] = '{ep: '{3'd2, 3'd2, 1'b1, 1'b0, 8'h33, 0, 0},
                   exp_lat: -1, exp_nbus: 0, exp_noff: 0};
        tbl[2] = '{ep: '{3'd2, 3'd1, 1'b0, 1'b0, 8'h33, 0, 0},
                   exp_lat: -1, exp_nbus: 0, exp_noff: 0};
        tbl[3] = '{ep: '{3'd7, 3'd6, 1'b1, 1'b0, 8'h81, 0, 2},
                   exp_lat: 4, exp_nbus: 2, exp_noff: 1};
        tbl[4] = '{ep: '{3'd1, 3'd0, 1'b1, 1'b0, 8'h1F, 3, 1},
                   exp_lat: 4, exp_nbus: 2, exp_noff: 1};
        tbl[5] = '{ep: '{3'd0, 3'd0, 1'b1, 1'b0, 8'h10, 0, 0},
                   exp_lat: -1, exp_nbus: 0, exp_noff: 0};
        tbl[6] = '{ep: '{3'd4, 3'd7, 1'b1, 1'b0, 8'h10, 0, 0},
                   exp_lat: -1, exp_nbus: 0, exp_noff: 0};
        tbl[7] = '{ep: '{3'd5, 3'd4, 1'b1, 1'b0, 8'h00, 1, 0},
                   exp_lat: 4, exp_nbus: 1, exp_noff: 0};

        foreach (tbl[i]) begin
            run_ep(tbl[i].ep, $sformatf("vec%0d", i), lat);
            chk($sformatf("vec%0d latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d nbus", i), bus_q.size(),
                tbl[i].exp_nbus);
            chk($sformatf("vec%0d noffer", i), off_q.size(),
                tbl[i].exp_noff);
            model(tbl[i].ep);
            cmp_logs($sformatf("vec%0d", i));
        end

        for (int k = 0; k < 40; k++) begin
            e.irq = 3'($urandom_range(0, 7));
            e.im = 3'($urandom_range(0, 7));
            e.ie = 1'($urandom_range(0, 3) != 0);
            e.nmi = 1'($urandom_range(0, 4) == 0);
            e.cause = ($urandom_range(0, 5) == 0) ? 8'h00
                                                  : 8'($urandom);
            e.bdly = $urandom_range(0, 3);
            e.cdly = $urandom_range(0, 3);
            run_ep(e, $sformatf("rnd%0d", k), lat);
            model(e);
            chk($sformatf("rnd%0d latency", k), lat, exp_lat);
            cmp_logs($sformatf("rnd%0d", k));
        end

        // NMI arriving while a cause read is outstanding
        clr_logs();
        rd_data = 8'h25;
        bus_dly = 3;
        core_dly = 1;
        irq_i = 3'd3;
        im_i = 3'd1;
        ie_i = 1'b1;
        wait_act(lat);
        chk("nmirc read start", cyc_o, 1'b1);
        irq_i = 3'd0;
        nmi_i = 1'b1;
        step();
        step();
        nmi_i = 1'b0;
        t = 0;
        t_fall = -1;
        t_nmi = -1;
        pc = cyc_o;
        while (t_nmi < 0 && t < 80) begin
            step();
            t++;
            if (pc && !cyc_o) t_fall = t;
            if (req_o && req_nmi_o) t_nmi = t;
            pc = cyc_o;
        end
        chk("nmirc hold gap", t_nmi - t_fall, 3);
        settle("nmirc");
        exp_bus.push_back(bus_t'{1'b0, 8'h00, 32'h0});
        exp_bus.push_back(bus_t'{1'b1, 8'h14, 32'h05});
        exp_off.push_back(off_t'{1'b0, 3'd3, 8'h25});
        exp_off.push_back(off_t'{1'b1, 3'd7, 8'hFE});
        cmp_logs("nmirc");

        // Cause read never acknowledged
        clr_logs();
        bus_en = 1'b0;
        irq_i = 3'd3;
        wait_act(lat);
        chk("tmo latency", lat, 4);
        irq_i = 3'd0;
        t = 0;
        while (cyc_o && t < 400) begin
            t++;
            step();
        end
        chk("tmo strobe cycles", t, 255);
        chk("tmo pulse", {timeout_o, cyc_o, stb_o}, 3'b100);
        settle("tmo");
        exp_tmo = 1;
        cmp_logs("tmo");
        bus_en = 1'b1;

        // Reset while reading, then while offering
        clr_logs();
        bus_en = 1'b0;
        irq_i = 3'd3;
        wait_act(lat);
        #3 rst_ni = 1'b0;
        #1 chk("rst in read", {cyc_o, stb_o, req_o}, 3'b000);
        step();
        step();
        rst_ni = 1'b1;
        bus_en = 1'b1;
        core_en = 1'b0;
        rd_data = 8'h4A;
        bus_dly = 0;
        clr_logs();
        wait_act(lat);
        chk("rst relaunch latency", lat, 4);
        t = 0;
        while (!req_o && t < 20) begin
            t++;
            step();
        end
        chk("rst offer up", req_o, 1'b1);
        #3 rst_ni = 1'b0;
        #1 chk("rst in offer",
               {cyc_o, stb_o, we_o, adr_o, dat_o, req_o, req_nmi_o,
                req_level_o, req_cause_o, spurious_o, timeout_o},
               64'h0);
        step();
        step();
        rst_ni = 1'b1;
        core_en = 1'b1;
        clr_logs();
        wait_act(lat);
        chk("rst reservice latency", lat, 4);
        irq_i = 3'd0;
        settle("rst");
        exp_bus.push_back(bus_t'{1'b0, 8'h00, 32'h0});
        exp_bus.push_back(bus_t'{1'b1, 8'h14, 32'h0A});
        exp_off.push_back(off_t'{1'b0, 3'd3, 8'h4A});
        cmp_logs("rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
